// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, drives the synchronous instruction memory and resolves
// jump/branch redirects from decode while keeping the delay-slot instruction.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             jb_valid,
    input  logic [3:0]       jb_ctrl,
    input  logic [31:0]      jb_pc,
    input  logic [15:0]      jb_imm,
    input  logic [25:0]      jb_jidx,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    output logic             imem_en,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_inst,
    output logic [31:0]      if_pc,
    output logic             if_valid,
    output logic             br_taken,
    output logic             addr_err,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [3:0] {
        JB_NONE = 4'd0,
        JB_J    = 4'd1,
        JB_JR   = 4'd2,
        JB_BEQ  = 4'd3,
        JB_BNE  = 4'd4,
        JB_BLEZ = 4'd5,
        JB_BGTZ = 4'd6,
        JB_BLTZ = 4'd7,
        JB_BGEZ = 4'd8
    } jb_code_e;

    logic [31:0]      pc_q, pc_d;
    logic             if_valid_q, if_valid_d;
    logic             addr_err_q, addr_err_d;
    logic [CNT_W-1:0] redirect_count_q, redirect_count_d;

    logic        taken;
    logic [31:0] target;
    logic [31:0] jb_pc_p4;
    logic [31:0] branch_off;
    logic        rs_zero;
    logic        rs_neg;

    assign jb_pc_p4   = jb_pc + 32'd4;
    assign branch_off = {{14{jb_imm[15]}}, jb_imm, 2'b00};
    assign rs_zero    = (rs_val == 32'd0);
    assign rs_neg     = rs_val[31];

    // Condition evaluation and redirect target for the instruction in decode.
    always_comb begin
        taken  = 1'b0;
        target = jb_pc_p4 + branch_off;
        case (jb_code_e'(jb_ctrl))
            JB_J: begin
                taken  = 1'b1;
                target = {jb_pc_p4[31:28], jb_jidx, 2'b00};
            end
            JB_JR: begin
                taken  = 1'b1;
                target = {rs_val[31:2], 2'b00};
            end
            JB_BEQ:  taken = (rs_val == rt_val);
            JB_BNE:  taken = (rs_val != rt_val);
            JB_BLEZ: taken = rs_neg | rs_zero;
            JB_BGTZ: taken = ~rs_neg & ~rs_zero;
            JB_BLTZ: taken = rs_neg;
            JB_BGEZ: taken = ~rs_neg;
            default: taken = 1'b0;
        endcase
    end

    assign br_taken = jb_valid & taken & ~stall & ~rst;

    // A stall re-reads the current address so the memory output stays stable.
    always_comb begin
        pc_d             = pc_q + 32'd4;
        if_valid_d       = 1'b1;
        addr_err_d       = 1'b0;
        redirect_count_d = redirect_count_q;
        if (stall) begin
            pc_d       = pc_q;
            if_valid_d = if_valid_q;
        end else if (br_taken) begin
            pc_d             = target;
            addr_err_d       = (jb_ctrl == JB_JR) && (rs_val[1:0] != 2'b00);
            redirect_count_d = redirect_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q             <= RESET_PC - 32'd4;
            if_valid_q       <= 1'b0;
            addr_err_q       <= 1'b0;
            redirect_count_q <= '0;
        end else begin
            pc_q             <= pc_d;
            if_valid_q       <= if_valid_d;
            addr_err_q       <= addr_err_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign imem_en        = ~rst;
    assign imem_addr      = pc_d;
    assign if_inst        = imem_rdata;
    assign if_pc          = pc_q;
    assign if_valid       = if_valid_q;
    assign addr_err       = addr_err_q;
    assign redirect_count = redirect_count_q;

endmodule
